dmem_resp_model: RTL and testbench

//  Synthesizable, parametrised data-memory responder for the pipeline core's data bus.

---
 rtl/dmem_resp_model.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_resp_model.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dmem_resp_model.sv
// Data-memory responder for the core's data bus.
// Serves loads and stores after a programmable number of wait states and acknowledges
// with an active-low one-cycle ack_n. It also decodes a STDOUT byte port, which is
// buffered in a FIFO with back-pressure, and a sticky EXIT flag.
module dmem_resp_model #(
  parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] STDOUT_ADDR = 32'hf000_0000,
  parameter logic [31:0] EXIT_ADDR   = 32'hff00_0000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mreq,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack_n,
  output logic        err,
  output logic        stdout_valid,
  output logic [7:0]  stdout_data,
  input  logic        stdout_ready,
  output logic        exit_req
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          CW        = $clog2(LATENCY + 1);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   off_q;
  logic          capture;

  // decode results for the captured request
  logic          misaligned, is_mem, mem_ok, std_push, exit_set, mmio_load, err_c;
  logic [3:0]    be;
  logic [31:0]   rdata_c, rdata_q;
  logic          ack_fire, stall, mem_we;

  // word storage with a registered read port
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   mem_rd_q;

  // stdout FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wp_q, rp_q;
  logic [FW:0]   fcnt_q;
  logic          fifo_full, push, pop;
  logic          exit_q;

  assign capture = (state_q == IDLE) && mreq;
  assign off_q   = addr_q - BASE_ADDR;

  // Address/size decode of the captured request
  always_comb begin
    misaligned = ((size_q == 2'b00) && (addr_q[1:0] != 2'b00)) ||
                 ((size_q == 2'b01) && addr_q[0]);
    is_mem     = off_q < MEM_BYTES;
    mem_ok     = is_mem && !misaligned;
    std_push   = (addr_q == STDOUT_ADDR) && wr_q && size_q[1];
    exit_set   = (addr_q == EXIT_ADDR) && wr_q && !misaligned;
    mmio_load  = ((addr_q == STDOUT_ADDR) || (addr_q == EXIT_ADDR)) && !wr_q && !misaligned;
    err_c      = !(mem_ok || std_push || exit_set || mmio_load);
    be         = 4'b1111;
    if (size_q[1]) begin
      be = 4'b0001 << addr_q[1:0];
    end else if (size_q[0]) begin
      be = addr_q[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Load lane extraction: right-justified and zero-extended
  always_comb begin
    rdata_c = 32'h0;
    if (!wr_q && mem_ok) begin
      if (size_q[1]) begin
        rdata_c = {24'h0, mem_rd_q[{addr_q[1:0], 3'b000} +: 8]};
      end else if (size_q[0]) begin
        rdata_c = addr_q[1] ? {16'h0, mem_rd_q[31:16]} : {16'h0, mem_rd_q[15:0]};
      end else begin
        rdata_c = mem_rd_q;
      end
    end
  end

  // A STDOUT push into a full FIFO holds the ack unless a pop frees a slot this cycle
  assign stall    = (state_q == ACK) && std_push && fifo_full && !pop;
  assign ack_fire = (state_q == ACK) && !stall && !rst;
  assign mem_we   = ack_fire && wr_q && mem_ok;
  assign push     = ack_fire && std_push;

  assign ack_n    = !ack_fire;
  assign err      = ack_fire && err_c;
  assign rdata    = ack_fire ? rdata_c : rdata_q;
  assign exit_req = exit_q;

  // Next-state logic for the request FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mreq) begin
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!mreq) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (!stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, request capture, held load data and sticky exit flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      exit_q  <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wr_q    <= write;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (ack_fire) begin
        rdata_q <= rdata_c;
      end
      if (ack_fire && exit_set) begin
        exit_q <= 1'b1;
      end
    end
  end

  // Memory: read the word at capture time, commit byte lanes at the end of ACK.
  // Store data is lane-positioned: the byte for offset o is taken from wdata[8o+7:8o].
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_rd_q <= mem[AW'((addr - BASE_ADDR) >> 2)];
    end
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[AW'(off_q >> 2)][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign fifo_full    = fcnt_q == (FW+1)'(FIFO_DEPTH);
  assign stdout_valid = fcnt_q != '0;
  assign pop          = stdout_valid && stdout_ready;
  assign stdout_data  = stdout_valid ? fifo_mem[rp_q] : 8'h00;

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + FW'(1);
      if (pop)  rp_q <= rp_q + FW'(1);
      fcnt_q <= fcnt_q + (FW+1)'(push) - (FW+1)'(pop);
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wp_q] <= wdata_q[7:0];
    end
  end
endmodule

// File: tb/tb_dmem_resp_model.sv
// Directed bench for dmem_resp_model: three instances with LATENCY 1, 3 and 4
// share the bus fields, each with its own mreq.
module tb_dmem_resp_model;
  localparam logic [31:0] STD  = 32'hf000_0000;
  localparam logic [31:0] EXIT = 32'hff00_0000;
  localparam logic [31:0] NOCHK = 32'hxxxx_xxxx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             write;
  logic [1:0]       size;
  logic [31:0]      addr, wdata;
  logic             stdout_ready;
  logic [2:0]       mreq;
  logic [2:0]       ack_n, err, stdout_valid, exit_req;
  logic [2:0][31:0] rdata;
  logic [2:0][7:0]  stdout_data;

  int n_cmp = 0;
  int n_bad = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
      dmem_resp_model #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .mreq(mreq[gi]), .write(write), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata[gi]), .ack_n(ack_n[gi]),
        .err(err[gi]), .stdout_valid(stdout_valid[gi]),
        .stdout_data(stdout_data[gi]), .stdout_ready(stdout_ready),
        .exit_req(exit_req[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transaction on instance u; exp_rd of all-X skips the data checks.
  task automatic req(input int u, input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rd,
                     input logic exp_err, input string tag);
    int lat;
    @(negedge clk);
    write = w; size = sz; addr = a; wdata = d; mreq[u] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack_n[u] !== 1'b0 && lat < 40);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, 32'(err[u]), 32'(exp_err));
    if (!$isunknown(exp_rd)) chk({tag, ".rdata"}, rdata[u], exp_rd);
    mreq[u] = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".ack_one_cycle"}, 32'(ack_n[u]), 32'd1);
    if (!$isunknown(exp_rd)) chk({tag, ".rdata_hold"}, rdata[u], exp_rd);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ch;
    rst = 1'b1; mreq = 3'b000; write = 1'b0; size = 2'b00;
    addr = 32'h0; wdata = 32'h0; stdout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk("reset.ack_n", 32'(ack_n[u]), 32'd1);
      chk("reset.err", 32'(err[u]), 32'd0);
      chk("reset.rdata", rdata[u], 32'd0);
      chk("reset.exit_req", 32'(exit_req[u]), 32'd0);
      chk("reset.stdout_valid", 32'(stdout_valid[u]), 32'd0);
      chk("reset.stdout_data", 32'(stdout_data[u]), 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    // LATENCY=1 word store then load
    req(0, 1'b1, 2'b00, 32'h0800_0010, 32'hdead_beef, 1, NOCHK, 1'b0, "l1_sw");
    req(0, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 1, 32'hdead_beef, 1'b0, "l1_lw");

    // LATENCY=3 sub-word lanes (byte/half data replicated across lanes)
    req(1, 1'b1, 2'b00, 32'h0800_0010, 32'hdead_beef, 3, NOCHK, 1'b0, "l3_sw");
    req(1, 1'b1, 2'b10, 32'h0800_0013, 32'h5a5a_5a5a, 3, NOCHK, 1'b0, "l3_sb");
    req(1, 1'b0, 2'b10, 32'h0800_0013, 32'h0, 3, 32'h0000_005a, 1'b0, "l3_lbu13");
    req(1, 1'b0, 2'b01, 32'h0800_0012, 32'h0, 3, 32'h0000_5aad, 1'b0, "l3_lhu12");
    req(1, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 3, 32'h5aad_beef, 1'b0, "l3_lw");
    req(1, 1'b1, 2'b01, 32'h0800_0010, 32'h1234_1234, 3, NOCHK, 1'b0, "l3_sh10");
    req(1, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 3, 32'h5aad_1234, 1'b0, "l3_lw2");
    req(1, 1'b0, 2'b10, 32'h0800_0011, 32'h0, 3, 32'h0000_0012, 1'b0, "l3_lbu11");

    // Misaligned, unmapped and MMIO corner cases
    req(1, 1'b0, 2'b00, 32'h0800_0002, 32'h0, 3, 32'h0, 1'b1, "mis_lw");
    req(1, 1'b1, 2'b01, 32'h0800_0011, 32'hffff_ffff, 3, 32'h0, 1'b1, "mis_sh");
    req(1, 1'b1, 2'b00, 32'h0000_0100, 32'hffff_ffff, 3, 32'h0, 1'b1, "unmap_sw");
    req(1, 1'b1, 2'b10, 32'h0800_1000, 32'hffff_ffff, 3, 32'h0, 1'b1, "unmap_sb_end");
    req(1, 1'b1, 2'b00, STD, 32'h4141_4141, 3, 32'h0, 1'b1, "std_sw_unmapped");
    req(1, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 3, 32'h5aad_1234, 1'b0, "mem_unchanged");
    req(1, 1'b0, 2'b00, STD, 32'h0, 3, 32'h0, 1'b0, "std_load");
    req(1, 1'b1, 2'b00, 32'h0800_0ffc, 32'h0bad_f00d, 3, NOCHK, 1'b0, "last_sw");
    req(1, 1'b0, 2'b00, 32'h0800_0ffc, 32'h0, 3, 32'h0bad_f00d, 1'b0, "last_lw");
    chk("l3.stdout_empty", 32'(stdout_valid[1]), 32'd0);

    // LATENCY=4: abort in WAIT leaves memory untouched
    req(2, 1'b1, 2'b00, 32'h0800_0010, 32'hcafe_f00d, 4, NOCHK, 1'b0, "l4_sw");
    @(negedge clk);
    write = 1'b1; size = 2'b00; addr = 32'h0800_0010; wdata = 32'h0; mreq[2] = 1'b1;
    @(posedge clk); #1; chk("abort.ack_c0", 32'(ack_n[2]), 32'd1);
    @(posedge clk); #1; chk("abort.ack_c1", 32'(ack_n[2]), 32'd1);
    @(negedge clk); mreq[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; chk("abort.no_ack", 32'(ack_n[2]), 32'd1);
    end
    req(2, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 4, 32'hcafe_f00d, 1'b0, "abort_lw");

    // STDOUT FIFO back-pressure on LATENCY=1 instance
    stdout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ch = 8'(8'h41 + i);
      req(0, 1'b1, 2'b10, STD, {4{ch}}, 1, NOCHK, 1'b0, "std_sb");
    end
    chk("fifo.valid_full", 32'(stdout_valid[0]), 32'd1);
    chk("fifo.head_A", 32'(stdout_data[0]), 32'h41);
    @(negedge clk);
    write = 1'b1; size = 2'b10; addr = STD; wdata = 32'h4949_4949; mreq[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; chk("fifo.ack_withheld", 32'(ack_n[0]), 32'd1);
    end
    @(negedge clk); stdout_ready = 1'b1; #1;
    chk("fifo.release_ack", 32'(ack_n[0]), 32'd0);
    chk("fifo.release_err", 32'(err[0]), 32'd0);
    chk("fifo.pop_A", 32'(stdout_data[0]), 32'h41);
    mreq[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("fifo.drain", 32'(stdout_data[0]), 32'(8'h41 + k));
      if (k == 1) chk("fifo.ack_once", 32'(ack_n[0]), 32'd1);
    end
    @(posedge clk); #1;
    chk("fifo.empty_valid", 32'(stdout_valid[0]), 32'd0);
    chk("fifo.empty_data", 32'(stdout_data[0]), 32'd0);

    // EXIT flag and reset in the middle of WAIT (LATENCY=4)
    stdout_ready = 1'b0;
    req(2, 1'b1, 2'b10, STD, 32'h5a5a_5a5a, 4, NOCHK, 1'b0, "l4_std_sb");
    chk("l4.fifo_valid", 32'(stdout_valid[2]), 32'd1);
    req(2, 1'b1, 2'b00, EXIT, 32'h0000_0001, 4, NOCHK, 1'b0, "exit_sw");
    chk("exit.set", 32'(exit_req[2]), 32'd1);
    req(2, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 4, 32'hcafe_f00d, 1'b0, "exit_then_lw");
    chk("exit.sticky", 32'(exit_req[2]), 32'd1);
    @(negedge clk);
    write = 1'b1; size = 2'b00; addr = 32'h0800_0010; wdata = 32'h1111_1111; mreq[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1; mreq[2] = 1'b0; #1;
    chk("rst.ack_during", 32'(ack_n[2]), 32'd1);
    @(posedge clk); #1;
    chk("rst.ack_n", 32'(ack_n[2]), 32'd1);
    chk("rst.exit_req", 32'(exit_req[2]), 32'd0);
    chk("rst.fifo_valid", 32'(stdout_valid[2]), 32'd0);
    chk("rst.fifo_data", 32'(stdout_data[2]), 32'd0);
    chk("rst.rdata", rdata[2], 32'd0);
    @(negedge clk); rst = 1'b0;
    req(2, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 4, 32'hcafe_f00d, 1'b0, "rst_no_commit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
